cr_isf_stream_gate: RTL
=======================

Name: cr_isf_stream_gate

Overview:
- Parametrised ingress stream gate for the ISF path: an AXI4-stream FIFO with selectable egress gating modes (free-run, single-step, trigger-halt).
- Successor to the fixed 64-bit ISF debug datapath: generalised in data width and FIFO depth, with a step credit counter, a halt/resume trigger on a masked data compare, and per-beat byte-count strobes.
- Sits between the upstream AXI4-stream source and the ISF core parser.

Parameters:
- DATA_W, 64, data width in bits; multiple of 8, minimum 8.
- DEPTH, 8, FIFO entries; power of 2, at least 2. AW = clog2(DEPTH).
- CRED_W, 4, width of the step credit counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- in_tvalid  in  1  ingress beat valid.
- in_tready  out  1  ingress ready.
- in_tdata  in  DATA_W  ingress data.
- in_tstrb  in  DATA_W/8  ingress byte strobes.
- in_tlast  in  1  ingress end of frame.
- out_tvalid  out  1  egress valid.
- out_tready  in  1  egress ready.
- out_tdata  out  DATA_W  egress data.
- out_tstrb  out  DATA_W/8  egress strobes.
- out_tlast  out  1  egress end of frame.
- cfg_mode  in  2  gating mode: 0 RUN, 1 STEP, 2 TRIG, 3 reserved (treated as RUN).
- cfg_match  in  DATA_W  trigger match value.
- cfg_mask  in  DATA_W  trigger compare mask; 1 = bit compared.
- step  in  1  single-cycle pulse that grants one egress beat in STEP mode.
- resume  in  1  single-cycle pulse that releases HALT.
- trig_hit  out  1  one-cycle pulse on trigger.
- trig_cap_data  out  DATA_W  captured trigger beat data.
- halted  out  1  state == HALT.
- fifo_level  out  AW+1  current occupancy.
- bytes_cnt_stb  out  1  ingress byte-count strobe.
- bytes_cnt_amt  out  clog2(DATA_W/8)+1  popcount of accepted in_tstrb.

Behaviour:
- Reset: FIFO is emptied and credits = 0. All outputs reset to 0: out_*, trig_*, halted, fifo_level, bytes_cnt_*. in_tready is 0 during reset and 1 on the first cycle after reset is released. Reset mid-frame discards all buffered beats.
- FIFO:
  - in_tready = (fifo_level != DEPTH), decoded from registered state.
  - Push on in_tvalid & in_tready. Pop on out_tvalid & out_tready. Push and pop in the same cycle leave the level unchanged.
  - Pointers are AW bits and wrap modulo DEPTH.
  - First-word fall-through: out_tdata/tstrb/tlast always show the head entry. Minimum latency from ingress accept to out_tvalid is 1 cycle.
- Egress gate (out_tvalid = !empty & open):
  - RUN: open = 1.
  - STEP: open = (credits != 0). A step pulse adds 1 credit, saturating at 2^CRED_W-1. Each pop subtracts 1. step and pop in the same cycle leave credits unchanged. Credits are cleared whenever cfg_mode != 1.
  - TRIG, with the FSM:
    - ARMED: open unless the head matches. A head match is !empty & (((head_data ^ cfg_match) & cfg_mask) == 0) & !skip.
    - On a head match in ARMED: out_tvalid = 0 that cycle. Next cycle: state becomes HALT, trig_cap_data = head_data, trig_hit = 1 for one cycle.
    - HALT: open = 0, halted = 1.
    - On resume in HALT: next cycle state returns to ARMED and skip is set, so the held beat does not retrigger. skip clears on the next pop.
    - resume outside HALT is ignored.
  - Leaving TRIG mode (cfg_mode != 2) from any state moves the FSM to ARMED next cycle and clears skip and halted. trig_cap_data holds its last value.
  - A mode change takes effect on the gate combinationally. Once out_tvalid is asserted, it is not deasserted before a handshake, except through a mode change, which is a software-ordered event.
- Byte count: one cycle after each ingress accept, bytes_cnt_stb = 1 and bytes_cnt_amt = popcount(in_tstrb). Both are 0 otherwise.
- No overflow is possible: pushes are blocked while full. Pops from an empty FIFO cannot occur.

Test Plan:
- RUN, DEPTH=8, out_tready=0, push 10 beats 0x1..0xA → in_tready drops after the 8th accept, fifo_level=8. Raise out_tready → beats emerge in order 0x1..0xA and fifo_level returns to 0.
- STEP mode, 4 beats buffered, step pulsed twice, out_tready=1 → exactly 2 beats out, credits 0, fifo_level=2. 20 step pulses with out_tready=0 → credits saturate at 15.
- TRIG, cfg_mask=0xFF, cfg_match=0x5A, stream 0x10, 0x5A, 0x20 → 0x10 passes. trig_hit pulses once, trig_cap_data=0x5A, halted=1, 0x5A is held. resume → 0x5A then 0x20 are forwarded with no second trig_hit.
- Simultaneous push and pop at fifo_level=3 for 5 cycles → fifo_level stays 3, and data order is preserved.
- Ingress beat with in_tstrb=0x0F on DATA_W=64 → bytes_cnt_stb=1 and bytes_cnt_amt=4 one cycle later.
- Assert rst_n=0 while in HALT with fifo_level=5 → all outputs 0, halted=0, fifo_level=0. After release, in_tready=1.

Source files
------------

// File: rtl/cr_isf_stream_gate.sv
// cr_isf_stream_gate: AXI4-stream ingress FIFO with RUN / STEP / TRIG egress gating for the ISF path.
module cr_isf_stream_gate #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 8,
    parameter  int CRED_W = 4,
    localparam int SW     = DATA_W / 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int BW     = $clog2(SW) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_tvalid,
    output logic              in_tready,
    input  logic [DATA_W-1:0] in_tdata,
    input  logic [SW-1:0]     in_tstrb,
    input  logic              in_tlast,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic [DATA_W-1:0] out_tdata,
    output logic [SW-1:0]     out_tstrb,
    output logic              out_tlast,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_match,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic              step,
    input  logic              resume,
    output logic              trig_hit,
    output logic [DATA_W-1:0] trig_cap_data,
    output logic              halted,
    output logic [AW:0]       fifo_level,
    output logic              bytes_cnt_stb,
    output logic [BW-1:0]     bytes_cnt_amt
);
    typedef enum logic {ARMED, HALT} state_t;
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [SW-1:0]     mem_strb_q [DEPTH];
    logic              mem_last_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       level_q, level_d;
    logic              rdy_q;
    logic [CRED_W-1:0] cred_q, cred_d;
    state_t            state_q, state_d;
    logic              skip_q, skip_d;
    logic              hit_q;
    logic [DATA_W-1:0] cap_q;
    logic              bstb_q;
    logic [BW-1:0]     bamt_q, bamt_d;
    logic              mode_step, mode_trig, empty, head_match, gate_open, push, pop, hit;

    assign mode_step     = cfg_mode == 2'd1;
    assign mode_trig     = cfg_mode == 2'd2;
    assign empty         = level_q == '0;
    assign out_tdata     = mem_data_q[rd_ptr_q];
    assign out_tstrb     = mem_strb_q[rd_ptr_q];
    assign out_tlast     = mem_last_q[rd_ptr_q];
    // skip masks the beat released by resume so it cannot retrigger
    assign head_match    = !empty && (((out_tdata ^ cfg_match) & cfg_mask) == '0) && !skip_q;
    assign gate_open     = mode_trig ? (state_q == ARMED && !head_match) : mode_step ? (cred_q != '0) : 1'b1;
    assign out_tvalid    = !empty && gate_open;
    assign in_tready     = rdy_q;
    assign push          = in_tvalid && rdy_q;
    assign pop           = out_tvalid && out_tready;
    assign hit           = mode_trig && state_q == ARMED && head_match;
    assign halted        = state_q == HALT;
    assign fifo_level    = level_q;
    assign trig_hit      = hit_q;
    assign trig_cap_data = cap_q;
    assign bytes_cnt_stb = bstb_q;
    assign bytes_cnt_amt = bamt_q;

    always_comb begin
        level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
        cred_d  = cred_q;
        if (!mode_step)
            cred_d = '0;
        else if (step && !pop && cred_q != '1)
            cred_d = cred_q + CRED_W'(1);
        else if (pop && !step)
            cred_d = cred_q - CRED_W'(1);
        state_d = state_q;
        skip_d  = skip_q;
        if (!mode_trig) begin
            state_d = ARMED;
            skip_d  = 1'b0;
        end else if (hit) begin
            state_d = HALT;
        end else if (state_q == HALT && resume) begin
            state_d = ARMED;
            skip_d  = 1'b1;
        end else if (pop) begin
            skip_d  = 1'b0;
        end
        bamt_d = '0;
        for (int i = 0; i < SW; i++)
            bamt_d = bamt_d + BW'(in_tstrb[i]);
        if (!push)
            bamt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_strb_q[i] <= '0;
                mem_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdy_q    <= 1'b0;
            cred_q   <= '0;
            state_q  <= ARMED;
            skip_q   <= 1'b0;
            hit_q    <= 1'b0;
            cap_q    <= '0;
            bstb_q   <= 1'b0;
            bamt_q   <= '0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= in_tdata;
                mem_strb_q[wr_ptr_q] <= in_tstrb;
                mem_last_q[wr_ptr_q] <= in_tlast;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            rdy_q   <= level_d != (AW+1)'(DEPTH);
            cred_q  <= cred_d;
            state_q <= state_d;
            skip_q  <= skip_d;
            hit_q   <= hit;
            if (hit)
                cap_q <= out_tdata;
            bstb_q  <= push;
            bamt_q  <= bamt_d;
        end
    end
endmodule
